// File: rtl/down_counter_pkg.sv
// Shared counter library package (counter_pkg): width limits and helpers
// used by the up and down counters.
package counter_pkg;

    localparam int COUNTER_W_MAX = 16;

    // All-ones pattern of the given width, zero-extended to the max width.
    function automatic logic [COUNTER_W_MAX-1:0] all_ones(input int width);
        logic [COUNTER_W_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < COUNTER_W_MAX; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/down_counter_if.sv
// Control/status bundle of the down counter.
// master drives en/load/d; slave returns the count and flags.
interface down_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             borrow;
    logic             busy;

    modport master (
        output en, load, d,
        input  q, zero, borrow, busy
    );

    modport slave (
        input  en, load, d,
        output q, zero, borrow, busy
    );

endinterface

// File: rtl/down_counter_core.sv
// Count register of the down counter: load, decrement, wrap/saturate,
// and substitution of a reload value on the 1 -> 0 step.
module down_counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] reload,
    output logic [WIDTH-1:0] q
);

    localparam logic [COUNTER_W_MAX-1:0] ONES_FULL = all_ones(WIDTH);
    localparam logic [WIDTH-1:0] ONES = ONES_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             q_zero;
    logic             q_one;
    logic             reload_nz;
    logic [WIDTH-1:0] floor_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] q_next;

    assign q_zero    = (q == '0);
    assign q_one     = (q == ONE);
    assign reload_nz = (reload != '0);
    assign floor_val = WRAP ? ONES : '0;

    assign dec_val = q_zero              ? floor_val :
                     (q_one & reload_nz) ? reload    :
                                           q - ONE;

    // Ternaries rather than if/else so an X on en or load reaches q.
    assign q_next = load ? d :
                    en   ? dec_val :
                           q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= q_next;
    end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter with terminal-count, borrow and busy flags.
// Optional macro AUTO_RELOAD_EN: reload d on the 1 -> 0 step (divider).
module down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    down_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] reload;
    logic             q_zero;
    logic             q_one;
    logic             reload_nz;
    logic             ends_run;
    logic             borrow;
    logic             busy;
    logic             borrow_next;
    logic             busy_next;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) reload_q <= '0;
        else       reload_q <= bus.load ? bus.d : reload_q;
    end

    assign reload = reload_q;
`else
    assign reload = '0;
`endif

    down_counter_core #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (bus.en),
        .load   (bus.load),
        .d      (bus.d),
        .reload (reload),
        .q      (q)
    );

    assign q_zero    = (q == '0);
    assign q_one     = (q == ONE);
    assign reload_nz = (reload != '0);

    // A decrement out of 1 ends the run unless a reload restarts it.
    assign ends_run = q_zero | (q_one & ~reload_nz);

    assign borrow_next = bus.load ? 1'b0 :
                         bus.en   ? (q_zero | (q_one & reload_nz)) :
                                    1'b0;

    assign busy_next = bus.load ? (bus.d != '0) :
                       bus.en   ? (ends_run ? 1'b0 : busy) :
                                  busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            borrow <= 1'b0;
            busy   <= 1'b0;
        end else begin
            borrow <= borrow_next;
            busy   <= busy_next;
        end
    end

    assign bus.q      = q;
    assign bus.zero   = q_zero;
    assign bus.borrow = borrow;
    assign bus.busy   = busy;

endmodule
